// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the rv_mem arbiter family.
package rv_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Requester indices into the req/gnt vectors.
  localparam int REQ_CORE = 0;
  localparam int REQ_LDR  = 1;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    logic [1:0] oh;
    if (idx == 1'b1) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// requester that did not win last time is chosen.
module rv_rr_pick
  import rv_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // Combinational one-hot selection from the request vector and last winner.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = idx_to_onehot(~last);
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Two-requester arbiter for the shared memory port of the multicycle core.
// Requester 0 is the core, requester 1 the loader/debug port. A grant is held
// for the whole access: MEM_LAT cycles of mem_en, then a one-cycle ack with
// registered read data. All outputs come straight from registers.
module rv_mem_arb
  import rv_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          mem_en,
  output logic          memrw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Counter wide enough to hold MEM_LAT-1; a single bit when MEM_LAT is 1.
  localparam int            CW       = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          last_r, last_s;
  logic [1:0]    gnt_r, gnt_s;
  logic          c_ack_r, c_ack_s;
  logic          l_ack_r, l_ack_s;
  logic          mem_en_r, mem_en_s;
  logic          memrw_r, memrw_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic [DW-1:0] rdata_r, rdata_s;

  logic [1:0]    req_s;
  logic [1:0]    pick_s;

  assign req_s = {l_req, c_req};

  rv_rr_pick u_pick (
    .req  (req_s),
    .last (last_r),
    .pick (pick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_s      = last_r;
    gnt_s       = gnt_r;
    c_ack_s     = 1'b0;
    l_ack_s     = 1'b0;
    mem_en_s    = mem_en_r;
    memrw_s     = memrw_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    rdata_s     = rdata_r;
    case (state_r)
      IDLE: begin
        gnt_s    = 2'b00;
        mem_en_s = 1'b0;
        if (pick_s != 2'b00) begin
          // Latch the winner's command so the memory side is stable from
          // registers for the whole access.
          state_s  = ACCESS;
          gnt_s    = pick_s;
          last_s   = pick_s[REQ_LDR];
          cnt_s    = CNT_LOAD;
          mem_en_s = 1'b1;
          if (pick_s[REQ_LDR]) begin
            memrw_s     = l_we;
            mem_addr_s  = l_addr;
            mem_wdata_s = l_wdata;
          end else begin
            memrw_s     = c_we;
            mem_addr_s  = c_addr;
            mem_wdata_s = c_wdata;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        mem_en_s = 1'b1;
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else begin
          // Last memory cycle: mem_rdata is valid now, ack goes out next.
          state_s  = DONE;
          mem_en_s = 1'b0;
          c_ack_s  = gnt_r[REQ_CORE];
          l_ack_s  = gnt_r[REQ_LDR];
          if (!memrw_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
        end
      end
      DONE: begin
        // The ack cycle never re-arbitrates; the grant is released here.
        state_s  = IDLE;
        gnt_s    = 2'b00;
        mem_en_s = 1'b0;
      end
      default: begin
        state_s  = IDLE;
        gnt_s    = 2'b00;
        mem_en_s = 1'b0;
        cnt_s    = CNT_ZERO;
      end
    endcase
  end

  // Registered control outputs, counter and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      last_r   <= 1'b1;
      gnt_r    <= 2'b00;
      c_ack_r  <= 1'b0;
      l_ack_r  <= 1'b0;
      mem_en_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      last_r   <= last_s;
      gnt_r    <= gnt_s;
      c_ack_r  <= c_ack_s;
      l_ack_r  <= l_ack_s;
      mem_en_r <= mem_en_s;
    end
  end

  // Registered memory-side command and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memrw_r     <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      rdata_r     <= {DW{1'b0}};
    end else begin
      memrw_r     <= memrw_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      rdata_r     <= rdata_s;
    end
  end

  assign c_ack     = c_ack_r;
  assign l_ack     = l_ack_r;
  assign gnt       = gnt_r;
  assign mem_en    = mem_en_r;
  assign memrw     = memrw_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;

endmodule
